// File: rtl/pad_port_bank_pkg.sv
// ----------------------------------------------------------------------------
// pad_port_bank_pkg : shared sizing constants for the GPIO pad bank  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package pad_port_bank_pkg;

  localparam int CHIP_PORT_A_WIDTH      = 16;
  localparam int PAD_FILT_CNT_W_DEFAULT = 4;
  localparam int PAD_SYNC_STAGES_MIN    = 2;

endpackage

`default_nettype wire

// File: rtl/pad_in_filter.sv
// ----------------------------------------------------------------------------
// pad_in_filter : per-pin synchroniser, glitch filter, edge detect, sticky flag  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module pad_in_filter
  import pad_port_bank_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT_W  = PAD_FILT_CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pad_din,
  input  logic                  i_ie,
  input  logic                  i_filt_en,
  input  logic [FILT_CNT_W-1:0] i_filt_len,
  input  logic                  i_rise_en,
  input  logic                  i_fall_en,
  input  logic                  i_irq_clr,
  output logic                  o_din,
  output logic                  o_flag
);

  localparam int SYNC_N = (SYNC_STAGES < PAD_SYNC_STAGES_MIN) ? PAD_SYNC_STAGES_MIN : SYNC_STAGES;
  localparam logic [FILT_CNT_W-1:0] c_CNT_ONE = {{(FILT_CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_N-1:0]     r_sync;
  logic [FILT_CNT_W-1:0] r_cnt;
  logic                  r_filt;
  logic                  r_filt_d;
  logic                  r_flag;
  logic                  w_raw;
  logic                  w_sync;
  logic                  w_rise;
  logic                  w_fall;

  assign w_raw  = i_pad_din & i_ie;
  assign w_sync = r_sync[SYNC_N-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_N-2:0], w_raw};
    end
  end

  // >= rather than == so a shortened filt_len mid-count still lets the value through
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (!i_filt_en) begin
      r_filt <= w_sync;
      r_cnt  <= '0;
    end else if (w_sync == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt >= i_filt_len) begin
      r_filt <= w_sync;
      r_cnt  <= '0;
    end else begin
      r_cnt  <= r_cnt + c_CNT_ONE;
    end
  end

  assign w_rise = r_filt & ~r_filt_d;
  assign w_fall = ~r_filt & r_filt_d;

  // set terms are ORed after the clear so a simultaneous edge wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt_d <= 1'b0;
      r_flag   <= 1'b0;
    end else begin
      r_filt_d <= r_filt;
      r_flag   <= (r_flag & ~i_irq_clr) | (w_rise & i_rise_en) | (w_fall & i_fall_en);
    end
  end

  assign o_din  = r_filt;
  assign o_flag = r_flag;

endmodule

`default_nettype wire

// File: rtl/std_pad.sv
// ----------------------------------------------------------------------------
// std_pad : behavioural bidirectional pad cell, tristate when oe is low  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module std_pad (
  input  logic dout,
  input  logic oe,
  output logic din,
  inout  wire  pad
);

  assign pad = oe ? dout : 1'bz;
  assign din = pad;

endmodule

`default_nettype wire

// File: rtl/pad_port_bank.sv
// ----------------------------------------------------------------------------
// pad_port_bank : parametrised GPIO pad ring with filtered, edge-flagged inputs  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module pad_port_bank
  import pad_port_bank_pkg::*;
#(
  parameter int PORT_WIDTH  = CHIP_PORT_A_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT_W  = PAD_FILT_CNT_W_DEFAULT
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [PORT_WIDTH-1:0] pmux_pad_dout,
  input  logic [PORT_WIDTH-1:0] pmux_pad_oe,
  input  logic [PORT_WIDTH-1:0] pmux_pad_ie,
  input  logic [PORT_WIDTH-1:0] filt_en,
  input  logic [FILT_CNT_W-1:0] filt_len,
  input  logic [PORT_WIDTH-1:0] edge_rise_en,
  input  logic [PORT_WIDTH-1:0] edge_fall_en,
  input  logic [PORT_WIDTH-1:0] irq_clr,
  output logic [PORT_WIDTH-1:0] pad_pmux_din,
  output logic [PORT_WIDTH-1:0] pad_irq_flag,
  output logic                  pad_irq,
  inout  wire  [PORT_WIDTH-1:0] PA
);

  logic [PORT_WIDTH-1:0] r_dout;
  logic [PORT_WIDTH-1:0] r_oe;
  logic [PORT_WIDTH-1:0] w_pad_din;

  // oe resets low so every pin stays tristated through reset
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_dout <= '0;
      r_oe   <= '0;
    end else begin
      r_dout <= pmux_pad_dout;
      r_oe   <= pmux_pad_oe;
    end
  end

  for (genvar gi = 0; gi < PORT_WIDTH; gi++) begin : g_pin
    std_pad u_pad (
      .dout (r_dout[gi]),
      .oe   (r_oe[gi]),
      .din  (w_pad_din[gi]),
      .pad  (PA[gi])
    );

    pad_in_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CNT_W  (FILT_CNT_W)
    ) u_filt (
      .clk        (clk_in),
      .rst        (rst),
      .i_pad_din  (w_pad_din[gi]),
      .i_ie       (pmux_pad_ie[gi]),
      .i_filt_en  (filt_en[gi]),
      .i_filt_len (filt_len),
      .i_rise_en  (edge_rise_en[gi]),
      .i_fall_en  (edge_fall_en[gi]),
      .i_irq_clr  (irq_clr[gi]),
      .o_din      (pad_pmux_din[gi]),
      .o_flag     (pad_irq_flag[gi])
    );
  end

  assign pad_irq = |pad_irq_flag;

endmodule

`default_nettype wire

// File: tb/tb_pad_port_bank.sv
// ----------------------------------------------------------------------------
// tb_pad_port_bank : directed and random checks of pad_port_bank against a queue-based model  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pad_port_bank;

  localparam int W  = 16;
  localparam int S  = 2;
  localparam int CW = 4;

  logic          clk_in = 1'b0;
  logic          rst;
  logic [W-1:0]  dout, oe, ie, fen, rie, fae, clr;
  logic [W-1:0]  tbv, tben;
  logic [CW-1:0] flen;
  logic [W-1:0]  din_o, flag_o;
  logic          irq_o;
  wire  [W-1:0]  PA;

  always #5 clk_in = ~clk_in;

  for (genvar gi = 0; gi < W; gi++) begin : g_tbdrv
    assign PA[gi] = tben[gi] ? tbv[gi] : 1'bz;
  end

  pad_port_bank #(
    .PORT_WIDTH  (W),
    .SYNC_STAGES (S),
    .FILT_CNT_W  (CW)
  ) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .pmux_pad_dout (dout),
    .pmux_pad_oe   (oe),
    .pmux_pad_ie   (ie),
    .filt_en       (fen),
    .filt_len      (flen),
    .edge_rise_en  (rie),
    .edge_fall_en  (fae),
    .irq_clr       (clr),
    .pad_pmux_din  (din_o),
    .pad_irq_flag  (flag_o),
    .pad_irq       (irq_o),
    .PA            (PA)
  );

  int total = 0;
  int bad   = 0;

  // reference: raw pin history queue, consecutive-disagreement run lengths, sticky flags
  logic [W-1:0] hist[$];
  logic [W-1:0] m_filt, m_fd, m_flag, m_oe, m_dout;
  int           run[W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < S; k++) hist.push_back('0);
    m_filt = '0; m_fd = '0; m_flag = '0; m_oe = '0; m_dout = '0;
    for (int i = 0; i < W; i++) run[i] = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] raw, syn, nf;
    if (rst) begin
      model_reset();
    end else begin
      raw    = tben & tbv & ie;
      syn    = hist[S-1];
      m_flag = (m_flag & ~clr) | (m_filt & ~m_fd & rie) | (~m_filt & m_fd & fae);
      m_fd   = m_filt;
      nf     = m_filt;
      for (int i = 0; i < W; i++) begin
        if (!fen[i]) begin
          nf[i]  = syn[i];
          run[i] = 0;
        end else if (syn[i] == m_filt[i]) begin
          run[i] = 0;
        end else begin
          run[i]++;
          if (run[i] > int'(flen)) begin
            nf[i]  = syn[i];
            run[i] = 0;
          end
        end
      end
      m_filt = nf;
      hist.push_front(raw);
      void'(hist.pop_back());
      m_oe   = oe;
      m_dout = dout;
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    model_step();
    #1;
    chk("din", din_o, m_filt);
    chk("flag", flag_o, m_flag);
    chk("irq", irq_o, (m_flag != '0));
    if (m_oe[0] && !tben[0]) chk("pa0", PA[0], m_dout[0]);
  endtask

  initial begin
    rst = 1'b1; oe = '1; dout = '1; ie = '0; fen = '0; flen = '0;
    rie = '0; fae = '0; clr = '0; tbv = '0; tben = '1;
    model_reset();

    // reset: pads tristated, all outputs low
    repeat (2) cyc();
    chk("rst_pa", PA, 16'h0000);
    chk("rst_din", din_o, 0);
    chk("rst_flag", flag_o, 0);
    chk("rst_irq", irq_o, 0);

    rst = 1'b0; oe = 16'h0001; dout = 16'h0001; tben = 16'hFFFE; ie = 16'hFFFE;
    cyc();
    chk("oe_pa0_hi", PA[0], 1);
    dout = 16'h0000;
    cyc();
    chk("dout_pa0_lo", PA[0], 0);
    dout = 16'h0001;
    repeat (4) cyc();

    // filter bypass, pin 3
    rie[3] = 1'b1; tbv[3] = 1'b1;
    repeat (2) cyc();
    chk("byp_c2", din_o[3], 0);
    cyc();
    chk("byp_c3", din_o[3], 1);
    chk("byp_flag_c3", flag_o[3], 0);
    cyc();
    chk("byp_flag_c4", flag_o[3], 1);
    chk("byp_irq_c4", irq_o, 1);
    clr[3] = 1'b1; cyc(); clr = '0;
    chk("clr3", flag_o[3], 0);

    // glitch rejection, pin 5, filt_len 4
    fen[5] = 1'b1; flen = 4'd4; rie[5] = 1'b1; fae[5] = 1'b1;
    cyc();
    tbv[5] = 1'b1;
    repeat (4) cyc();
    tbv[5] = 1'b0;
    repeat (8) begin
      cyc();
      chk("glitch4", din_o[5], 0);
    end
    tbv[5] = 1'b1;
    repeat (5) cyc();
    tbv[5] = 1'b0;
    cyc();
    chk("pulse5_c6", din_o[5], 0);
    cyc();
    chk("pulse5_c7", din_o[5], 1);
    repeat (12) cyc();
    clr = '1; cyc(); clr = '0;

    // set/clear collision, pin 7
    fae[7] = 1'b1; tbv[7] = 1'b1;
    repeat (5) cyc();
    tbv[7] = 1'b0;
    repeat (3) cyc();
    chk("fall_din7", din_o[7], 0);
    clr[7] = 1'b1; cyc(); clr = '0;
    chk("coll_flag7", flag_o[7], 1);
    clr[7] = 1'b1; cyc(); clr = '0;
    chk("clr_flag7", flag_o[7], 0);
    chk("clr_irq", irq_o, 0);

    // input-enable gating, pin 2
    fae[2] = 1'b1; tbv[2] = 1'b1;
    repeat (5) cyc();
    ie[2] = 1'b0;
    repeat (2) cyc();
    chk("ie_c2", din_o[2], 1);
    cyc();
    chk("ie_c3", din_o[2], 0);
    cyc();
    chk("ie_flag", flag_o[2], 1);

    // reset while pin 1 is mid-count with filt_len 15
    fen[1] = 1'b1; flen = 4'd15; rie[1] = 1'b1; tbv[1] = 1'b1;
    repeat (6) cyc();
    chk("midcnt_din1", din_o[1], 0);
    rst = 1'b1; cyc(); rst = 1'b0;
    repeat (17) cyc();
    chk("rst_c17", din_o[1], 0);
    cyc();
    chk("rst_c18", din_o[1], 1);
    cyc();
    chk("rst_flag1", flag_o[1], 1);

    // randomized traffic
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) tbv = tbv ^ (W'($urandom) & W'($urandom) & 16'hFFFE);
      if ($urandom_range(0, 31) == 0) fen = W'($urandom);
      if ($urandom_range(0, 31) == 0) flen = CW'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0) rie = W'($urandom);
      if ($urandom_range(0, 31) == 0) fae = W'($urandom);
      if ($urandom_range(0, 63) == 0) ie = W'($urandom) & 16'hFFFE;
      clr     = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      dout[0] = 1'($urandom);
      rst     = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; clr = '0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pad_port_bank.md
# pad_port_bank

Parametrised successor to the fixed 16-pin port A pad ring. It instantiates one `std_pad` per pin, registers the output and output-enable path, and runs each input through a synchroniser and a programmable glitch filter. Each pin also has rising/falling edge detection with sticky interrupt flags. It sits between the pin mux (`pmux_*`) and the chip pins, replacing hand-instantiated per-pin pads for any GPIO port width.

## Interface
- `PORT_WIDTH`, default `CHIP_PORT_A_WIDTH` (16): number of pins.
- `SYNC_STAGES`, default 2: input synchroniser depth, minimum 2.
- `FILT_CNT_W`, default 4: width of the glitch-filter length and counter.

Ports:
- `clk_in`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `pmux_pad_dout`  in  PORT_WIDTH  output data per pin.
- `pmux_pad_oe`  in  PORT_WIDTH  output enable per pin; 1 = drive.
- `pmux_pad_ie`  in  PORT_WIDTH  input enable per pin.
- `filt_en`  in  PORT_WIDTH  per-pin glitch filter enable.
- `filt_len`  in  FILT_CNT_W  global filter length, shared by all pins.
- `edge_rise_en`  in  PORT_WIDTH  set the flag on a filtered rising edge.
- `edge_fall_en`  in  PORT_WIDTH  set the flag on a filtered falling edge.
- `irq_clr`  in  PORT_WIDTH  one-cycle clear pulse per flag.
- `pad_pmux_din`  out  PORT_WIDTH  filtered input value.
- `pad_irq_flag`  out  PORT_WIDTH  sticky edge flags.
- `pad_irq`  out  1  OR of all `pad_irq_flag` bits.
- `PA`  inout  PORT_WIDTH  chip pins.

## Operation
- **Output path:** `pmux_pad_dout` and `pmux_pad_oe` are registered once, then feed `std_pad .dout` and `.oe`. Reset value 0, so all pins are tristated during and after reset.
- **Raw input:** raw = `std_pad .din` AND `pmux_pad_ie`. A pin with ie=0 reads 0 into the synchroniser.
- **Synchroniser:** SYNC_STAGES flops per pin, reset 0; the last stage is `sync`.
- **Filter disabled (`filt_en`=0):** `filt` <= `sync` every cycle; the counter is held at 0.
- **Filter enabled:**
  - If `sync` == `filt`, the counter is set to 0.
  - Else, if counter == `filt_len`, then `filt` <= `sync` and the counter is set to 0.
  - Else, the counter increments.
  - Net effect: `filt` changes only after `sync` has disagreed with it for `filt_len`+1 consecutive cycles. `filt_len`=0 behaves the same as filter disabled.
  - A glitch shorter than `filt_len`+1 cycles resets the counter and causes no output change.
- **Filter control changes:**
  - Toggling `filt_en` takes effect on the next cycle and clears the counter.
  - Changing `filt_len` mid-count compares against the new value.
  - If the counter already exceeds the new `filt_len`, then `filt` <= `sync` on the next disagreeing cycle (compare with >=, not ==).
- **Output data:** `pad_pmux_din` = `filt` register, reset 0.
- **Edge detect:** `filt_d` is `filt` delayed by one cycle, reset 0.
  - rise = `filt` & ~`filt_d`.
  - fall = ~`filt` & `filt_d`.
- **Flags:** flag <= (flag & ~`irq_clr`) | (rise & `edge_rise_en`) | (fall & `edge_fall_en`).
  - If set and clear happen in the same cycle, set wins.
  - Flags reset to 0. Flags are not cleared by disabling `edge_*_en`.
- **`pad_irq`:** combinational OR of the flag registers.
- **Reset mid-operation:** all synchroniser, filter, counter, `filt_d`, flag and output registers go to 0 in the reset cycle. A pin held high through reset produces a rising edge after release; if `edge_rise_en` is set, that edge sets the flag.

## Timing
- Output latency: `pmux_pad_oe`/`dout` change to pad drive is 1 cycle.
- Input latency, filter disabled: pad change to `pad_pmux_din` is SYNC_STAGES+1 cycles.
- Input latency, filter enabled: pad change held stable to `pad_pmux_din` is SYNC_STAGES+`filt_len`+1 cycles.
- Flag latency: `pad_irq_flag` and `pad_irq` assert 1 cycle after `pad_pmux_din` changes.
- `irq_clr` latency: the flag clears 1 cycle after the pulse.
- All pins are fully independent; there is no cross-pin arbitration.

## Structure
- `chip_params.v` gains `CHIP_PORT_A_WIDTH` reuse plus `PAD_FILT_CNT_W_DEFAULT`. No new typedefs.
- Sub-module `pad_in_filter`, one per pin inside a generate loop. It contains the synchroniser, filter counter, `filt`, `filt_d` and the flag register. The `std_pad` instance sits beside it in the same generate body.
- The top level holds only the registered output path, the generate loop and the `pad_irq` OR reduction.

## Test plan
- **Reset:** assert `rst` with `pmux_pad_oe`=all 1s → after reset `PA` is all Z and every output is 0. Then 1 cycle later pin 0 drives `pmux_pad_dout[0]`.
- **Filter bypass:** filt_en=0, drive PA[3] 0→1 → `pad_pmux_din[3]`=1 exactly 3 cycles later (SYNC_STAGES=2). With `edge_rise_en[3]`=1, `pad_irq_flag[3]`=1 and `pad_irq`=1 on cycle 4.
- **Glitch rejection:** filt_en[5]=1, filt_len=4. A 4-cycle high pulse on PA[5] → `pad_pmux_din[5]` stays 0. A 5-cycle pulse → it goes 1 at cycle 2+4+1=7.
- **Set/clear collision:** falling edge on pin 7 in the same cycle as `irq_clr[7]`=1 → flag stays 1. A later `irq_clr[7]` alone → flag is 0 the next cycle and `pad_irq`=0.
- **ie gating:** PA[2] held at 1, `pmux_pad_ie[2]` 1→0 → `pad_pmux_din[2]` falls 3 cycles later, and the fall flag sets if enabled.
- **Reset mid-count:** filt_len=15 with a count in progress; assert `rst` for 1 cycle with PA[1] held at 1. After release, `pad_pmux_din[1]`=1 after SYNC_STAGES+16 cycles, and the rise flag sets.
